otter_intr_ctrl: RTL and testbench

//  Memory-mapped interrupt controller upstream of the OTTER MCU INTR input. Synchronises NUM_SRC

---
 rtl/otter_intr_pkg.sv | 17 +
 rtl/otter_intr_sync.sv | 40 ++++
 rtl/otter_intr_ctrl.sv | 106 ++++++++++
 tb/tb_otter_intr_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_intr_pkg.sv
// otter_intr_pkg: register offsets and shared types for the OTTER interrupt controller
//   OFF_*            byte offsets of the five registers inside the window
//   CLAIM_VALID_BIT  bit of the CLAIM word that flags a valid source id
//   src_id_t         source index as reported in CLAIM[4:0]
package otter_intr_pkg;

    localparam logic [31:0] OFF_PEND   = 32'h0000_0000;
    localparam logic [31:0] OFF_ENABLE = 32'h0000_0004;
    localparam logic [31:0] OFF_MODE   = 32'h0000_0008;
    localparam logic [31:0] OFF_CLAIM  = 32'h0000_000C;
    localparam logic [31:0] OFF_GEN    = 32'h0000_0010;

    localparam int CLAIM_VALID_BIT = 31;

    typedef logic [4:0] src_id_t;

endpackage

// File: rtl/otter_intr_sync.sv
// otter_intr_sync: two-flop synchroniser plus rising-edge detect for one interrupt source
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   src      raw asynchronous request line
//   level    synchronised level of src
//   rise     one-cycle pulse when the synchronised level goes 0->1
module otter_intr_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic src,
    output logic level,
    output logic rise
);

    logic meta, sync, dly;
    logic filled, armed;

    // A source that is already high when reset releases must not look like a
    // fresh edge while the chain refills. Edges are only honoured once a real
    // low has been sampled after the first post-reset clock.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            dly    <= 1'b0;
            filled <= 1'b0;
            armed  <= 1'b0;
        end else begin
            meta   <= src;
            sync   <= meta;
            dly    <= sync;
            filled <= 1'b1;
            armed  <= armed | (filled & ~meta);
        end
    end

    assign level = sync;
    assign rise  = sync & ~dly & armed;

endmodule

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: memory-mapped interrupt controller feeding the OTTER MCU INTR input
//   CLK         system clock, all state on rising edge
//   RESET_N     asynchronous active-low reset
//   IRQ_SRC     raw asynchronous request lines, bit i = source i
//   IOBUS_ADDR  MCU IO byte address
//   IOBUS_OUT   MCU IO write data
//   IOBUS_WR    MCU IO write strobe
//   IOBUS_IN    registered read data (0 outside the register window)
//   INTR        registered interrupt request to the MCU
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        IOBUS_IN,
    output logic               INTR
);

    logic [NUM_SRC-1:0] sync_lvl, sync_rise;
    logic [NUM_SRC-1:0] pend, enable, mode;
    logic [NUM_SRC-1:0] pend_nxt, w1c, mode_chg, act;
    logic [NUM_SRC-1:0] wdata;
    logic               gen;
    logic               wr_pend, wr_enable, wr_mode, wr_gen;
    src_id_t            claim_id;
    logic               claim_vld;
    logic [31:0]        rd_data;
    logic               unused_wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        otter_intr_sync u_sync (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .src     (IRQ_SRC[g]),
            .level   (sync_lvl[g]),
            .rise    (sync_rise[g])
        );
    end

    assign wdata        = IOBUS_OUT[NUM_SRC-1:0];
    assign unused_wdata = ^IOBUS_OUT[31:NUM_SRC];

    assign wr_pend   = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + OFF_PEND);
    assign wr_enable = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + OFF_ENABLE);
    assign wr_mode   = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + OFF_MODE);
    assign wr_gen    = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + OFF_GEN);

    assign w1c      = wr_pend ? wdata : '0;
    assign mode_chg = wr_mode ? (wdata ^ mode) : '0;

    // Edge bits: a new rise wins over a simultaneous W1C. Level bits simply
    // track the synchronised line. Any bit whose mode is being changed is
    // forced clear, including one that would have been edge-set.
    assign pend_nxt = ~mode_chg & ((mode & (sync_rise | (pend & ~w1c))) | (~mode & sync_lvl));

    assign act = pend & enable;

    // Scan from the top down so the lowest active index is the last to assign.
    always_comb begin
        claim_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (act[i]) claim_id = src_id_t'(i);
        claim_vld = |act;
    end

    always_comb begin
        rd_data = '0;
        case (IOBUS_ADDR)
            BASE_ADDR + OFF_PEND:   rd_data[NUM_SRC-1:0] = pend;
            BASE_ADDR + OFF_ENABLE: rd_data[NUM_SRC-1:0] = enable;
            BASE_ADDR + OFF_MODE:   rd_data[NUM_SRC-1:0] = mode;
            BASE_ADDR + OFF_CLAIM: begin
                rd_data[CLAIM_VALID_BIT] = claim_vld;
                rd_data[4:0]             = claim_id;
            end
            BASE_ADDR + OFF_GEN:    rd_data[0] = gen;
            default:                rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend     <= '0;
            enable   <= '0;
            mode     <= '0;
            gen      <= 1'b0;
            IOBUS_IN <= '0;
            INTR     <= 1'b0;
        end else begin
            pend     <= pend_nxt;
            enable   <= wr_enable ? wdata : enable;
            mode     <= wr_mode ? wdata : mode;
            gen      <= wr_gen ? IOBUS_OUT[0] : gen;
            IOBUS_IN <= rd_data;
            INTR     <= gen & (|act);
        end
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed self-checking bench for otter_intr_ctrl
module tb_otter_intr_ctrl;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK;
    logic        RESET_N;
    logic [7:0]  IRQ_SRC;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    int checks = 0;
    int errors = 0;

    otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IRQ_SRC    (IRQ_SRC),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic wr_abs(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        wr_abs(BASE + off, data);
    endtask

    task automatic rd_abs(input logic [31:0] addr, output logic [31:0] data);
        IOBUS_ADDR = addr;
        @(negedge CLK);
        data = IOBUS_IN;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data);
        rd_abs(BASE + off, data);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (3) @(negedge CLK);
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL reset_intr got %b want 0", INTR);
        end
        checks++;
        if (IOBUS_IN !== 32'h0) begin
            errors++;
            $display("FAIL reset_iobus_in got %h want 00000000", IOBUS_IN);
        end
        IRQ_SRC = 8'h00;
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        for (int r = 0; r < 5; r++) begin
            rd(32'(r * 4), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg_%0d got %h want 00000000", r, d);
            end
        end
    endtask

    task automatic test_edge_basic;
        logic [31:0] d;
        wr(32'h10, 32'h1);
        wr(32'h04, 32'h04);
        wr(32'h08, 32'h04);
        IRQ_SRC[2] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (INTR !== (e == 4)) begin
                errors++;
                $display("FAIL edge_latency_e%0d got %b want %b", e, INTR, (e == 4));
            end
            if (e == 3) IRQ_SRC[2] = 1'b0;
        end
        @(negedge CLK);
        rd(32'h0C, d);
        checks++;
        if (d !== 32'h8000_0002) begin
            errors++;
            $display("FAIL edge_claim got %h want 80000002", d);
        end
        wr(32'h00, 32'h04);
        checks++;
        if (INTR !== 1'b1) begin
            errors++;
            $display("FAIL w1c_intr_same got %b want 1", INTR);
        end
        @(negedge CLK);
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL w1c_intr_next got %b want 0", INTR);
        end
        rd(32'h00, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL w1c_pend got %h want 00000000", d);
        end
    endtask

    task automatic test_priority;
        logic [31:0] d;
        wr(32'h04, 32'hFF);
        wr(32'h08, 32'hFF);
        IRQ_SRC = 8'h22;
        repeat (4) @(negedge CLK);
        IRQ_SRC = 8'h00;
        repeat (4) @(negedge CLK);
        rd(32'h0C, d);
        checks++;
        if (d !== 32'h8000_0001) begin
            errors++;
            $display("FAIL prio_claim_1 got %h want 80000001", d);
        end
        rd(32'h00, d);
        checks++;
        if (d !== 32'h22) begin
            errors++;
            $display("FAIL prio_pend got %h want 00000022", d);
        end
        wr(32'h00, 32'h02);
        rd(32'h0C, d);
        checks++;
        if (d !== 32'h8000_0005) begin
            errors++;
            $display("FAIL prio_claim_5 got %h want 80000005", d);
        end
        wr(32'h00, 32'h20);
        rd(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL prio_claim_none got %h want 00000000", d);
        end
    endtask

    task automatic test_level;
        logic [31:0] d;
        wr(32'h08, 32'hF7);
        IRQ_SRC[3] = 1'b1;
        repeat (4) @(negedge CLK);
        rd(32'h00, d);
        checks++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL level_pend got %h want 00000008", d);
        end
        wr(32'h00, 32'h08);
        rd(32'h00, d);
        checks++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL level_w1c_ignored got %h want 00000008", d);
        end
        checks++;
        if (INTR !== 1'b1) begin
            errors++;
            $display("FAIL level_intr got %b want 1", INTR);
        end
        IRQ_SRC[3] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (INTR !== (e < 4)) begin
                errors++;
                $display("FAIL level_drop_e%0d got %b want %b", e, INTR, (e < 4));
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        wr(32'h08, 32'hFF);
        IRQ_SRC[0] = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        wr(32'h00, 32'h01);
        rd(32'h00, d);
        checks++;
        if (d !== 32'h01) begin
            errors++;
            $display("FAIL set_wins_pend got %h want 00000001", d);
        end
        IRQ_SRC[0] = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (INTR !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_intr got %b want 1", INTR);
        end
        wr(32'h08, 32'hFE);
        rd(32'h00, d);
        checks++;
        if (d !== 32'h00) begin
            errors++;
            $display("FAIL mode_flip_pend got %h want 00000000", d);
        end
    endtask

    task automatic test_gen_and_window;
        logic [31:0] d;
        IRQ_SRC[6] = 1'b1;
        repeat (4) @(negedge CLK);
        IRQ_SRC[6] = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (INTR !== 1'b1) begin
            errors++;
            $display("FAIL gen_pre_intr got %b want 1", INTR);
        end
        wr(32'h10, 32'h0);
        @(negedge CLK);
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL gen_off_intr got %b want 0", INTR);
        end
        rd(32'h0C, d);
        checks++;
        if (d !== 32'h8000_0006) begin
            errors++;
            $display("FAIL gen_off_claim got %h want 80000006", d);
        end
        wr_abs(BASE + 32'h14, 32'hFFFF_FFFF);
        rd(32'h04, d);
        checks++;
        if (d !== 32'hFF) begin
            errors++;
            $display("FAIL window_enable got %h want 000000ff", d);
        end
        rd(32'h08, d);
        checks++;
        if (d !== 32'hFE) begin
            errors++;
            $display("FAIL window_mode got %h want 000000fe", d);
        end
        rd(32'h00, d);
        checks++;
        if (d !== 32'h40) begin
            errors++;
            $display("FAIL window_pend got %h want 00000040", d);
        end
        rd(32'h10, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL window_gen got %h want 00000000", d);
        end
        rd_abs(BASE + 32'h14, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL window_read_off got %h want 00000000", d);
        end
        rd_abs(32'h0000_0004, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL window_read_far got %h want 00000000", d);
        end
        wr(32'h04, 32'h0F);
        checks++;
        if (IOBUS_IN !== 32'hFF) begin
            errors++;
            $display("FAIL read_during_write got %h want 000000ff", IOBUS_IN);
        end
        rd(32'h04, d);
        checks++;
        if (d !== 32'h0F) begin
            errors++;
            $display("FAIL read_after_write got %h want 0000000f", d);
        end
    endtask

    task automatic test_reset_mid_request;
        logic [31:0] d;
        wr(32'h10, 32'h1);
        wr(32'h08, 32'h02);
        IRQ_SRC = 8'h03;
        IOBUS_ADDR = BASE;
        repeat (5) @(negedge CLK);
        checks++;
        if (INTR !== 1'b1 || IOBUS_IN !== 32'h03) begin
            errors++;
            $display("FAIL mid_pre got intr %b in %h want 1 00000003", INTR, IOBUS_IN);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (INTR !== 1'b0 || IOBUS_IN !== 32'h0) begin
            errors++;
            $display("FAIL mid_async got intr %b in %h want 0 00000000", INTR, IOBUS_IN);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        wr(32'h08, 32'h01);
        repeat (6) @(negedge CLK);
        rd(32'h00, d);
        checks++;
        if (d !== 32'h02) begin
            errors++;
            $display("FAIL mid_release_pend got %h want 00000002", d);
        end
    endtask

    initial begin
        RESET_N    = 1'b0;
        IRQ_SRC    = 8'hFF;
        IOBUS_ADDR = BASE;
        IOBUS_OUT  = 32'h0;
        IOBUS_WR   = 1'b0;
        test_reset;
        test_edge_basic;
        test_priority;
        test_level;
        test_set_wins;
        test_gen_and_window;
        test_reset_mid_request;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
